image_rx_framer: RTL

- Receive-side counterpart of the results transmitter: turns the raw byte stream from uart_rcvr into one framed, flow-controlled pixel stream for the face-detection pipeline.
- Buffers bytes in a small FIFO and drives uart_rts as real RTS/CTS flow control, replacing the tied-high fpga_can_receive.
- Counts pixels per frame, marks the last pixel, and holds RTS low after a frame until the coordinate results have been sent back.

---
 rtl/image_rx_pkg.sv | 20 ++
 rtl/byte_fifo.sv | 81 ++++++++
 rtl/image_rx_framer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/image_rx_pkg.sv
// -----------------------------------------------------------------------------
// image_rx_pkg
// Shared types for the receive-side image framer: FSM state encoding, the
// pixel byte type and the frame sync byte used when IMAGE_RX_FRAME_SYNC_EN
// is defined.
// -----------------------------------------------------------------------------
package image_rx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } state_t;

   typedef logic [7:0] pixel_t;

   localparam pixel_t SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/byte_fifo.sv
// -----------------------------------------------------------------------------
// byte_fifo
// First-word-fall-through byte FIFO. The head entry is visible on data_o
// whenever empty_o is low. A push while full is accepted only when a pop
// happens in the same cycle; an unqualified push while full is ignored.
//
// Ports
//   clock    in   system clock
//   reset    in   synchronous active-high reset (pointers/count only)
//   push_i   in   write data_i
//   data_i   in   byte to write
//   pop_i    in   advance the head (ignored when empty)
//   data_o   out  head entry
//   full_o   out  DEPTH entries held
//   empty_o  out  no entries held
//   count_o  out  occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module byte_fifo
   import image_rx_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          push_i,
   input  pixel_t        data_i,
   input  logic          pop_i,
   output pixel_t        data_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);

   pixel_t          mem_q [DEPTH];
   logic [AW-1:0]   wr_q, wr_d;
   logic [AW-1:0]   rd_q, rd_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            wr_en, rd_en;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign data_o  = mem_q[rd_q];

   // A full FIFO can still take a byte when the head leaves in the same cycle.
   assign rd_en = pop_i && !empty_o;
   assign wr_en = push_i && (!full_o || rd_en);

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (wr_en) wr_d = wr_q + AW'(1);
      if (rd_en) rd_d = rd_q + AW'(1);
      case ({wr_en, rd_en})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clock) begin
      if (wr_en) mem_q[wr_q] <= data_i;
   end

endmodule

// File: rtl/image_rx_framer.sv
// -----------------------------------------------------------------------------
// image_rx_framer
// Turns the raw uart_rcvr byte stream into a framed, flow-controlled pixel
// stream. Bytes are buffered in a byte_fifo; uart_rts provides RTS/CTS flow
// control. Each frame is IMG_W*IMG_H bytes; the final pixel is flagged with
// pix_last, and RTS stays low after the frame until results_done.
//
// Optional feature (macro IMAGE_RX_FRAME_SYNC_EN): in IDLE only SYNC_BYTE
// starts a frame; it is consumed and not forwarded, other IDLE bytes are
// silently discarded. Without the macro the first IDLE byte is pixel 0.
//
// Ports
//   clock          in   system clock
//   reset          in   synchronous active-high reset
//   uart_data      in   byte from uart_rcvr
//   uart_data_rdy  in   single-cycle strobe, uart_data valid
//   uart_rts       out  1 = FPGA can receive
//   pix_data       out  pixel to pipeline (FIFO head)
//   pix_valid      out  pix_data valid
//   pix_ready      in   pipeline accepts pixel
//   pix_last       out  final pixel of the frame
//   frame_done     out  one-cycle pulse after the last pixel handshake
//   results_done   in   results fully sent back to host
//   busy           out  FSM not in IDLE
//   overrun        out  sticky: a byte was dropped
// -----------------------------------------------------------------------------
module image_rx_framer
   import image_rx_pkg::*;
#(
   parameter int IMG_W      = 160,
   parameter int IMG_H      = 120,
   parameter int FIFO_DEPTH = 16,
   parameter int RTS_MARGIN = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] uart_data,
   input  logic       uart_data_rdy,
   output logic       uart_rts,
   output logic [7:0] pix_data,
   output logic       pix_valid,
   input  logic       pix_ready,
   output logic       pix_last,
   output logic       frame_done,
   input  logic       results_done,
   output logic       busy,
   output logic       overrun
);

   localparam int N     = IMG_W * IMG_H;
   localparam int CNT_W = $clog2(N + 1);
   localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

   localparam logic [CNT_W-1:0] N_C       = CNT_W'(N);
   localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(N - 1);
   localparam logic [OCC_W-1:0] RTS_THRSH = OCC_W'(FIFO_DEPTH - RTS_MARGIN);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   rx_cnt_q, rx_cnt_d;
   logic [CNT_W-1:0]   tx_cnt_q, tx_cnt_d;
   logic               ovr_q, ovr_d;
   logic               rts_q, rts_d;
   logic               fdone_q, fdone_d;

   logic               push, pop, push_room;
   logic               fifo_full, fifo_empty;
   logic [OCC_W-1:0]   fifo_count;
   pixel_t             fifo_head;

   byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push_i  (push),
      .data_i  (uart_data),
      .pop_i   (pop),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign pix_valid  = !fifo_empty;
   assign pix_data   = fifo_head;
   assign pop        = pix_valid && pix_ready;
   assign push_room  = !fifo_full || pop;
   assign pix_last   = pix_valid && (tx_cnt_q == LAST_C);
   assign uart_rts   = rts_q;
   assign frame_done = fdone_q;
   assign busy       = (state_q != IDLE);
   assign overrun    = ovr_q;

   always_comb begin
      state_d  = state_q;
      rx_cnt_d = rx_cnt_q;
      tx_cnt_d = tx_cnt_q;
      ovr_d    = ovr_q;
      fdone_d  = 1'b0;
      push     = 1'b0;
      rts_d    = rts_q;

      if (pop) tx_cnt_d = tx_cnt_q + CNT_W'(1);

      case (state_q)
         IDLE: begin
            // The FIFO is always empty in IDLE, so a pushed byte always fits.
            if (uart_data_rdy) begin
`ifdef IMAGE_RX_FRAME_SYNC_EN
               if (uart_data == SYNC_BYTE) begin
                  state_d  = RECV;
                  rx_cnt_d = '0;
                  tx_cnt_d = '0;
                  ovr_d    = 1'b0;
               end
`else
               state_d  = RECV;
               push     = 1'b1;
               rx_cnt_d = CNT_W'(1);
               tx_cnt_d = '0;
               ovr_d    = 1'b0;
`endif
            end
         end
         RECV: begin
            if (uart_data_rdy) begin
               if (push_room) begin
                  push     = 1'b1;
                  rx_cnt_d = rx_cnt_q + CNT_W'(1);
               end else begin
                  ovr_d = 1'b1;
               end
            end
         end
         DRAIN: begin
            // The frame is complete; anything else from the host is excess.
            if (uart_data_rdy) ovr_d = 1'b1;
            if (pop && pix_last) begin
               state_d = HOLD;
               fdone_d = 1'b1;
            end
         end
         HOLD: begin
            if (uart_data_rdy) ovr_d = 1'b1;
            if (results_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if ((state_d == RECV) && (rx_cnt_d == N_C)) state_d = DRAIN;

      // RTS follows the occupancy register, so it lags occupancy by a cycle.
      case (state_d)
         IDLE:    rts_d = 1'b1;
         RECV:    rts_d = (fifo_count < RTS_THRSH);
         default: rts_d = 1'b0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         rx_cnt_q <= '0;
         tx_cnt_q <= '0;
         ovr_q    <= 1'b0;
         rts_q    <= 1'b1;
         fdone_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         rx_cnt_q <= rx_cnt_d;
         tx_cnt_q <= tx_cnt_d;
         ovr_q    <= ovr_d;
         rts_q    <= rts_d;
         fdone_q  <= fdone_d;
      end
   end

endmodule
